// File: rtl/inst_buffer.sv
// inst_buffer: compacting circular instruction FIFO between predecode and decode
module inst_buffer #(
  parameter int BLK_SIZE  = 4,
  parameter int DEPTH     = 16,
  parameter int DEC_WIDTH = 4,
  parameter int FSQ_WIDTH = 4,
  localparam int OW = $clog2(BLK_SIZE),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BLK_SIZE-1:0]            in_en,
  input  logic [BLK_SIZE*32-1:0]         in_inst,
  input  logic [FSQ_WIDTH-1:0]           in_fsq_idx,
  input  logic                           flush,
  output logic                           full,
  input  logic                           dec_ready,
  output logic [DEC_WIDTH-1:0]           out_valid,
  output logic [DEC_WIDTH*32-1:0]        out_inst,
  output logic [DEC_WIDTH*FSQ_WIDTH-1:0] out_fsq_idx,
  output logic [DEC_WIDTH*OW-1:0]        out_offset
);
  logic [31:0]          mem_inst [DEPTH];
  logic [FSQ_WIDTH-1:0] mem_fsq  [DEPTH];
  logic [OW-1:0]        mem_off  [DEPTH];
  logic [AW-1:0]        head, tail;
  logic [AW:0]          count, n_in, n_out;
  logic [AW-1:0]        pos [BLK_SIZE];
  logic                 enq;
  // each enabled lane lands at tail plus the number of enabled lanes below it
  always_comb begin
    n_in = '0;
    for (int i = 0; i < BLK_SIZE; i++) begin
      pos[i] = tail + n_in[AW-1:0];
      n_in = n_in + (AW+1)'(in_en[i]);
    end
  end
  assign full  = ((AW+1)'(DEPTH) - count) < (AW+1)'(BLK_SIZE);
  assign enq   = !full && !flush;
  assign n_out = dec_ready ? ((count < (AW+1)'(DEC_WIDTH)) ? count : (AW+1)'(DEC_WIDTH)) : '0;
  always_ff @(posedge clk)
    for (int i = 0; i < BLK_SIZE; i++)
      if (enq && in_en[i]) begin
        mem_inst[pos[i]] <= in_inst[32*i +: 32];
        mem_fsq[pos[i]]  <= in_fsq_idx;
        mem_off[pos[i]]  <= OW'(i);
      end
  always_ff @(posedge clk)
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out[AW-1:0];
      tail  <= tail + (enq ? n_in[AW-1:0] : '0);
      count <= count + (enq ? n_in : '0) - n_out;
    end
  always_comb begin
    out_valid   = '0;
    out_inst    = '0;
    out_fsq_idx = '0;
    out_offset  = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      out_valid[i]                     = count > (AW+1)'(i);
      out_inst[32*i +: 32]             = mem_inst[head + AW'(i)];
      out_fsq_idx[FSQ_WIDTH*i +: FSQ_WIDTH] = mem_fsq[head + AW'(i)];
      out_offset[OW*i +: OW]           = mem_off[head + AW'(i)];
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed stimulus with a scoreboard-driven output monitor
module tb_inst_buffer;
  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  fsq;
    logic [1:0]  off;
  } ent_t;
  logic         clk = 0, rst = 1, flush = 0, dec_ready = 0, full;
  logic [3:0]   in_en = 0, in_fsq_idx = 0, out_valid;
  logic [127:0] in_inst = 0, out_inst;
  logic [15:0]  out_fsq_idx;
  logic [7:0]   out_offset;
  ent_t         sb [$];
  ent_t         me;
  int           tests = 0, fails = 0, mn;
  logic [3:0]   mv;
  bit           mon_on = 0;
  inst_buffer dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_inst(in_inst), .in_fsq_idx(in_fsq_idx),
    .flush(flush), .full(full), .dec_ready(dec_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_fsq_idx(out_fsq_idx), .out_offset(out_offset)
  );
  always #5 clk = ~clk;
  // monitor: thermometer must track the expected occupancy; consumed slots pop the scoreboard
  always @(negedge clk) if (mon_on) begin
    mn = sb.size() < 4 ? sb.size() : 4;
    mv = 4'((1 << mn) - 1);
    tests++;
    if (out_valid !== mv) begin
      fails++;
      $display("FAIL out_valid_therm act=%b exp=%b", out_valid, mv);
    end
    if (dec_ready && !flush)
      for (int i = 0; i < 4; i++)
        if (out_valid[i]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL slot%0d_unexpected act=%h exp=none", i, out_inst[32*i +: 32]);
          end else begin
            me = sb.pop_front();
            if ({out_inst[32*i +: 32], out_fsq_idx[4*i +: 4], out_offset[2*i +: 2]} !== me) begin
              fails++;
              $display("FAIL slot%0d_data act=%h/%h/%0d exp=%h/%h/%0d", i, out_inst[32*i +: 32],
                       out_fsq_idx[4*i +: 4], out_offset[2*i +: 2], me.inst, me.fsq, me.off);
            end
          end
        end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic [3:0] en, input logic [127:0] w, input logic [3:0] f,
                     input logic rdy, input logic fl, input logic acc);
    in_en = en; in_inst = w; in_fsq_idx = f; dec_ready = rdy; flush = fl;
    @(posedge clk); #1;
    if (fl) sb.delete();
    else if (acc)
      for (int i = 0; i < 4; i++)
        if (en[i]) sb.push_back({w[32*i +: 32], f, 2'(i)});
    in_en = 0; dec_ready = 0; flush = 0;
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(4'b0000, '0, 4'h0, rdy, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_full", 32'(full), 0);
    chk("reset_valid", 32'(out_valid), 0);
    mon_on = 1;
    idle(5, 1'b0);
    chk("idle_valid", 32'(out_valid), 0);
    // compaction: lanes 1 and 3 only
    cyc(4'b1010, {32'hD, 32'hC, 32'hB, 32'hA}, 4'h3, 1'b0, 1'b0, 1'b1);
    chk("comp_valid", 32'(out_valid), 32'b0011);
    chk("comp_s0_inst", out_inst[31:0], 32'hB);
    chk("comp_s0_off", 32'(out_offset[1:0]), 1);
    chk("comp_s0_fsq", 32'(out_fsq_idx[3:0]), 3);
    chk("comp_s1_inst", out_inst[63:32], 32'hD);
    chk("comp_s1_off", 32'(out_offset[3:2]), 3);
    chk("comp_s1_fsq", 32'(out_fsq_idx[7:4]), 3);
    idle(1, 1'b1);
    // fill: 12 entries leaves exactly one block of room, 16 is full
    for (int b = 0; b < 3; b++)
      cyc(4'b1111, {32'(b*4+3)+32'h100, 32'(b*4+2)+32'h100, 32'(b*4+1)+32'h100, 32'(b*4)+32'h100},
          4'(b), 1'b0, 1'b0, 1'b1);
    chk("count12_full", 32'(full), 0);
    cyc(4'b1111, {32'h10F, 32'h10E, 32'h10D, 32'h10C}, 4'h3, 1'b0, 1'b0, 1'b1);
    chk("count16_full", 32'(full), 1);
    cyc(4'b1111, {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hBAD0}, 4'h9, 1'b0, 1'b0, 1'b0);
    chk("ignored_full", 32'(full), 1);
    idle(1, 1'b1);
    chk("after_pop_full", 32'(full), 0);
    idle(3, 1'b1);
    chk("drained_valid", 32'(out_valid), 0);
    // move head/tail from 2 to 14, then a block that straddles the wrap
    for (int b = 0; b < 3; b++) cyc(4'b1111, {4{32'h200 + 32'(b)}}, 4'h1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    cyc(4'b1111, {32'h3, 32'h2, 32'h1, 32'h0}, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("wrap_valid", 32'(out_valid), 32'b1111);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_s%0d_inst", i), out_inst[32*i +: 32], 32'(i));
      chk($sformatf("wrap_s%0d_off", i), 32'(out_offset[2*i +: 2]), 32'(i));
    end
    idle(1, 1'b1);
    // simultaneous enqueue and dequeue of three
    cyc(4'b0111, {32'h0, 32'hE2, 32'hE1, 32'hE0}, 4'h2, 1'b0, 1'b0, 1'b1);
    cyc(4'b0111, {32'h0, 32'hF2, 32'hF1, 32'hF0}, 4'h6, 1'b1, 1'b0, 1'b1);
    chk("simul_valid", 32'(out_valid), 32'b0111);
    chk("simul_s0_inst", out_inst[31:0], 32'hF0);
    idle(1, 1'b1);
    // flush beats a concurrent push and pop
    cyc(4'b1111, {32'h43, 32'h42, 32'h41, 32'h40}, 4'h1, 1'b0, 1'b0, 1'b1);
    cyc(4'b1111, {32'h47, 32'h46, 32'h45, 32'h44}, 4'h1, 1'b0, 1'b0, 1'b1);
    cyc(4'b0001, {32'h0, 32'h0, 32'h0, 32'h48}, 4'h1, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_valid", 32'(out_valid), 32'b1111);
    cyc(4'b1111, {32'hDEAD3, 32'hDEAD2, 32'hDEAD1, 32'hDEAD0}, 4'h8, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_full", 32'(full), 0);
    cyc(4'b0110, {32'h0, 32'h62, 32'h61, 32'h0}, 4'h7, 1'b0, 1'b0, 1'b1);
    chk("post_flush_valid", 32'(out_valid), 32'b0011);
    chk("post_flush_s0_inst", out_inst[31:0], 32'h61);
    chk("post_flush_s0_off", 32'(out_offset[1:0]), 1);
    chk("post_flush_s0_fsq", 32'(out_fsq_idx[3:0]), 7);
    idle(2, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
